// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : RV32I opcodes, integer ALU funct codes and dispatch decode types.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OpOP    = 7'b0110011;
  localparam logic [6:0] OpOPIMM = 7'b0010011;
  localparam logic [6:0] OpLUI   = 7'b0110111;
  localparam logic [6:0] OpAUIPC = 7'b0010111;

  // ALU funct is {funct7, funct3}
  localparam logic [9:0] AluADD  = 10'h000;
  localparam logic [9:0] AluSUB  = 10'h100;
  localparam logic [9:0] AluSLL  = 10'h001;
  localparam logic [9:0] AluSLT  = 10'h002;
  localparam logic [9:0] AluSLTU = 10'h003;
  localparam logic [9:0] AluXOR  = 10'h004;
  localparam logic [9:0] AluSRL  = 10'h005;
  localparam logic [9:0] AluSRA  = 10'h105;
  localparam logic [9:0] AluOR   = 10'h006;
  localparam logic [9:0] AluAND  = 10'h007;

  typedef enum logic [1:0] {
    Src1Rs1  = 2'd0,
    Src1Zero = 2'd1,
    Src1Pc   = 2'd2
  } src1_sel_e;

  typedef enum logic {
    Src2Rs2 = 1'b0,
    Src2Imm = 1'b1
  } src2_sel_e;

  typedef struct packed {
    logic      alu_en;
    logic [9:0] funct;
    src1_sel_e src1_sel;
    src2_sel_e src2_sel;
  } alu_dec_t;

endpackage

`default_nettype wire

// File: rtl/alu_funct_decode.sv
// ============================================================================
// Module   : alu_funct_decode
// Brief    : Combinational opcode/funct decode into ALU funct and operand selects.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_funct_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       imm10_i,
  output alu_dec_t   dec_o
);

  always_comb begin
    dec_o = '{alu_en: 1'b0, funct: AluADD, src1_sel: Src1Rs1, src2_sel: Src2Rs2};
    case (opcode_i)
      OpOP: begin
        dec_o.alu_en = 1'b1;
        dec_o.funct  = {funct7_i, funct3_i};
      end
      OpOPIMM: begin
        dec_o.alu_en   = 1'b1;
        dec_o.src2_sel = Src2Imm;
        // Only the right-shift group encodes an arithmetic flag in the immediate
        if (funct3_i == 3'b101) dec_o.funct = {1'b0, imm10_i, 5'b0, funct3_i};
        else                    dec_o.funct = {7'b0, funct3_i};
      end
      OpLUI: begin
        dec_o.alu_en   = 1'b1;
        dec_o.src1_sel = Src1Zero;
        dec_o.src2_sel = Src2Imm;
      end
      OpAUIPC: begin
        dec_o.alu_en   = 1'b1;
        dec_o.src1_sel = Src1Pc;
        dec_o.src2_sel = Src2Imm;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_dispatch.sv
// ============================================================================
// Module   : alu_dispatch
// Brief    : Integer ALU issue stage with operand select and result forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_dispatch
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic [4:0]      i_rd,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic            i_stall,
  output logic            o_en,
  output logic [9:0]      o_funct,
  output logic [XLEN-1:0] o_src1,
  output logic [XLEN-1:0] o_src2,
  output logic            o_stall
);

  logic            en_q, en_d;
  logic [9:0]      funct_q, funct_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic            fwd1_q, fwd1_d;
  logic            fwd2_q, fwd2_d;
  logic            last_vld_q, last_vld_d;
  logic [4:0]      last_rd_q, last_rd_d;

  alu_dec_t        w_dec;
  logic [XLEN:0]   w_rs1_res;
  logic [XLEN:0]   w_rs2_res;

  alu_funct_decode u_decode (
    .opcode_i (i_opcode),
    .funct3_i (i_funct3),
    .funct7_i (i_funct7),
    .imm10_i  (i_imm[10]),
    .dec_o    (w_dec)
  );

  // Returns {forward_flag, data}; a forwarded source takes the ALU result later
  function automatic logic [XLEN:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 5'd0)                          resolve = '0;
    else if (last_vld_q && rs == last_rd_q)  resolve = {1'b1, {XLEN{1'b0}}};
    else if (i_wb_en && rs == i_wb_rd)       resolve = {1'b0, i_wb_data};
    else                                     resolve = {1'b0, rf};
  endfunction

  assign w_rs1_res = resolve(i_rs1, i_rs1_data);
  assign w_rs2_res = resolve(i_rs2, i_rs2_data);

  always_comb begin
    en_d       = en_q;
    funct_d    = funct_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    fwd1_d     = fwd1_q;
    fwd2_d     = fwd2_q;
    last_vld_d = last_vld_q;
    last_rd_d  = last_rd_q;
    if (!i_stall) begin
      en_d = 1'b0;
      if (i_valid && w_dec.alu_en) begin
        en_d    = 1'b1;
        funct_d = w_dec.funct;
        case (w_dec.src1_sel)
          Src1Rs1: {fwd1_d, src1_d} = w_rs1_res;
          Src1Pc:  {fwd1_d, src1_d} = {1'b0, i_pc};
          default: {fwd1_d, src1_d} = '0;
        endcase
        if (w_dec.src2_sel == Src2Imm) {fwd2_d, src2_d} = {1'b0, i_imm};
        else                           {fwd2_d, src2_d} = w_rs2_res;
        last_rd_d  = i_rd;
        last_vld_d = (i_rd != 5'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      funct_q    <= AluADD;
      src1_q     <= '0;
      src2_q     <= '0;
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
      last_vld_q <= 1'b0;
      last_rd_q  <= 5'd0;
    end else begin
      en_q       <= en_d;
      funct_q    <= funct_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
      last_vld_q <= last_vld_d;
      last_rd_q  <= last_rd_d;
    end
  end

  // The ALU captured the producer at the edge this op was accepted, so its result is current
  assign o_src1  = fwd1_q ? i_alu_res : src1_q;
  assign o_src2  = fwd2_q ? i_alu_res : src2_q;
  assign o_en    = en_q;
  assign o_funct = funct_q;
  assign o_ready = !i_stall;
  assign o_stall = i_stall;

endmodule

`default_nettype wire

// File: tb/tb_alu_dispatch.sv
// ============================================================================
// Module   : tb_alu_dispatch
// Brief    : Scoreboard bench for alu_dispatch with a behavioural integer ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_dispatch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [31:0] i_rs1_data, i_rs2_data, i_imm, i_pc;
  logic        i_wb_en;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic [31:0] i_alu_res;
  logic        i_stall;
  logic        o_en;
  logic [9:0]  o_funct;
  logic [31:0] o_src1, o_src2;
  logic        o_stall;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [9:0]  f;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  exp_t exp_q[$];

  alu_dispatch #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_pc(i_pc),
    .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_alu_res(i_alu_res), .i_stall(i_stall),
    .o_en(o_en), .o_funct(o_funct), .o_src1(o_src1), .o_src2(o_src2), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      AluADD:  alu_f = a + b;
      AluSUB:  alu_f = a - b;
      AluSLL:  alu_f = a << b[4:0];
      AluSLT:  alu_f = {31'b0, $signed(a) < $signed(b)};
      AluSLTU: alu_f = {31'b0, a < b};
      AluXOR:  alu_f = a ^ b;
      AluSRL:  alu_f = a >> b[4:0];
      AluSRA:  alu_f = $signed(a) >>> b[4:0];
      AluOR:   alu_f = a | b;
      AluAND:  alu_f = a & b;
      default: alu_f = 32'h0;
    endcase
  endfunction

  // Integer ALU model: registers a result when an op is presented and not stalled
  always @(posedge clk) begin
    if (rst)                  i_alu_res <= 32'h0;
    else if (o_en && !o_stall) i_alu_res <= alu_f(o_funct, o_src1, o_src2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every op the ALU consumes must match the head of the scoreboard
  always @(negedge clk) begin
    if (o_en === 1'b1 && o_stall === 1'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dispatch: got funct %h src1 %h src2 %h, expected none",
                 o_funct, o_src1, o_src2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_funct !== e.f || o_src1 !== e.s1 || o_src2 !== e.s2) begin
          n_fail++;
          $display("FAIL %s: got funct %h src1 %h src2 %h expected funct %h src1 %h src2 %h",
                   e.name, o_funct, o_src1, o_src2, e.f, e.s1, e.s2);
        end
      end
    end
  end

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc);
    i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_funct7 = f7;
    i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_rs1_data = d1; i_rs2_data = d2;
    i_imm = imm; i_pc = pc;
  endtask

  // Called just after a rising edge; presents one op for one accepting edge
  task automatic issue(input string name, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic has_exp, input logic [9:0] ef,
                       input logic [31:0] es1, input logic [31:0] es2);
    set_op(op, f3, f7, rd, rs1, rs2, d1, d2, imm, pc);
    if (has_exp) exp_q.push_back('{name, ef, es1, es2});
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_stall = 1'b0;
    i_opcode = '0; i_funct3 = '0; i_funct7 = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_imm = '0; i_pc = '0;
    i_wb_en = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_en",    {31'b0, o_en},    32'h0);
    chk("reset_funct", {22'b0, o_funct}, 32'h0);
    chk("reset_src1",  o_src1,           32'h0);
    chk("reset_src2",  o_src2,           32'h0);
    chk("reset_ready", {31'b0, o_ready}, 32'h1);
    chk("reset_stall", {31'b0, o_stall}, 32'h0);
    @(posedge clk); #1;

    issue("add_x3", OpOP, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 32'h0,
          1'b1, AluADD, 32'd5, 32'd7);
    issue("sub_fwd", OpOP, 3'b000, 7'h20, 5'd5, 5'd3, 5'd1, 32'd0, 32'd5, 32'h0, 32'h0,
          1'b1, AluSUB, 32'd12, 32'd5);
    @(posedge clk); #1;
    issue("fwd_after_bubble", OpOP, 3'b000, 7'h00, 5'd6, 5'd5, 5'd0, 32'h0, 32'hDEAD, 32'h0, 32'h0,
          1'b1, AluADD, 32'd7, 32'd0);
    issue("rd_x0_producer", OpOP, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 32'h0,
          1'b1, AluADD, 32'd5, 32'd7);
    issue("or_rs_x0", OpOP, 3'b110, 7'h00, 5'd8, 5'd0, 5'd2, 32'h55, 32'd7, 32'h0, 32'h0,
          1'b1, AluOR, 32'd0, 32'd7);
    i_wb_en = 1'b1; i_wb_rd = 5'd10; i_wb_data = 32'h100;
    issue("wb_bypass", OpOP, 3'b000, 7'h00, 5'd9, 5'd10, 5'd11, 32'd1, 32'd3, 32'h0, 32'h0,
          1'b1, AluADD, 32'h100, 32'd3);
    i_wb_en = 1'b0;
    issue("srai", OpOPIMM, 3'b101, 7'h20, 5'd4, 5'd3, 5'd2, 32'h80000000, 32'h0, 32'h402, 32'h0,
          1'b1, AluSRA, 32'h80000000, 32'h402);
    issue("srli", OpOPIMM, 3'b101, 7'h00, 5'd5, 5'd6, 5'd2, 32'h80, 32'h0, 32'h002, 32'h0,
          1'b1, AluSRL, 32'h80, 32'h2);
    issue("lui", OpLUI, 3'b000, 7'h00, 5'd1, 5'd5, 5'd5, 32'hFFFF, 32'hFFFF, 32'h12345000, 32'h0,
          1'b1, AluADD, 32'h0, 32'h12345000);
    issue("auipc", OpAUIPC, 3'b000, 7'h00, 5'd12, 5'd1, 5'd1, 32'hFFFF, 32'hFFFF, 32'h1000, 32'h100,
          1'b1, AluADD, 32'h100, 32'h1000);
    issue("branch_ignored", 7'b1100011, 3'b000, 7'h00, 5'd13, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0,
          1'b0, AluADD, 32'h0, 32'h0);
    issue("fwd_past_other_op", OpOP, 3'b000, 7'h00, 5'd14, 5'd13, 5'd12, 32'h33, 32'hBAD, 32'h0, 32'h0,
          1'b1, AluADD, 32'h33, 32'h1100);

    // Stall with a new op held valid; the visible op must freeze
    i_stall = 1'b1;
    set_op(OpOP, 3'b111, 7'h00, 5'd15, 5'd1, 5'd2, 32'hF0, 32'h3C, 32'h0, 32'h0);
    exp_q.push_back('{"and_after_stall", AluAND, 32'hF0, 32'h3C});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", {31'b0, o_ready}, 32'h0);
      chk("stall_out",   {31'b0, o_stall}, 32'h1);
      chk("stall_en",    {31'b0, o_en},    32'h1);
      chk("stall_src1",  o_src1,           32'h33);
      chk("stall_src2",  o_src2,           32'h1100);
      @(posedge clk); #1;
    end
    i_stall = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;

    // Reset lands on the same edge as a valid op, which must be discarded
    set_op(OpOP, 3'b000, 7'h00, 5'd16, 5'd1, 5'd2, 32'd9, 32'd9, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_en",    {31'b0, o_en},    32'h0);
    chk("rst_mid_funct", {22'b0, o_funct}, 32'h0);
    chk("rst_mid_src1",  o_src1,           32'h0);
    chk("rst_mid_src2",  o_src2,           32'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
